// File: rtl/reg_debug_access_if.sv
// Host-side command and response channels of the register debug access port.
// The master drives requests and accepts responses; the slave is the debug initiator.
interface reg_debug_access_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err
    );
endinterface

// File: rtl/reg_debug_access.sv
// Debug initiator for the register file extra port: halts the core, performs a read,
// write or full dump through extra_*, and returns results on the response channel.
module reg_debug_access #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic               CLK,
    input  logic               RSTn,
    reg_debug_access_if.slave  bus,
    output logic               halt_req_o,
    input  logic               halted_i,
    output logic [ADDR_W-1:0]  extra_addr_o,
    output logic               extra_write_enable_o,
    output logic [DATA_W-1:0]  extra_write_data_o,
    input  logic [DATA_W-1:0]  extra_read_data_i
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HALT    = 3'd1,
        ST_WR      = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_CAP  = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    localparam logic [1:0]        OP_WRITE = 2'b01;
    localparam logic [1:0]        OP_DUMP  = 2'b10;
    localparam logic [1:0]        OP_ILL   = 2'b11;
    localparam logic [ADDR_W-1:0] IDX_LAST = {ADDR_W{1'b1}};

    state_t            state_q;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] idx_q;
    logic              halt_req_q;
    logic [ADDR_W-1:0] extra_addr_q;
    logic              extra_we_q;
    logic [DATA_W-1:0] extra_wdata_q;
    logic              rsp_valid_q;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_last_q;
    logic              rsp_err_q;

    logic              req_hs_s;
    logic              rsp_hs_s;
    logic [ADDR_W-1:0] idx_next_s;

    assign bus.req_ready = (state_q == ST_IDLE);
    assign req_hs_s      = bus.req_valid && (state_q == ST_IDLE);
    assign rsp_hs_s      = rsp_valid_q && bus.rsp_ready;
    assign idx_next_s    = idx_q + ADDR_W'(1);

    // Transaction sequencer; every output it drives is registered here.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            idx_q         <= '0;
            halt_req_q    <= 1'b0;
            extra_addr_q  <= '0;
            extra_we_q    <= 1'b0;
            extra_wdata_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_addr_q    <= '0;
            rsp_data_q    <= '0;
            rsp_last_q    <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_hs_s) begin
                        op_q   <= bus.req_op;
                        addr_q <= bus.req_addr;
                        data_q <= bus.req_data;
                        idx_q  <= '0;
                        if (bus.req_op == OP_ILL) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_addr_q  <= bus.req_addr;
                            rsp_data_q  <= '0;
                            rsp_last_q  <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            halt_req_q <= 1'b1;
                            state_q    <= ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    if (halted_i) begin
                        if (op_q == OP_WRITE) begin
                            state_q       <= ST_WR;
                            extra_addr_q  <= addr_q;
                            extra_wdata_q <= data_q;
                            extra_we_q    <= 1'b1;
                        end else begin
                            state_q      <= ST_RD_ADDR;
                            extra_addr_q <= (op_q == OP_DUMP) ? '0 : addr_q;
                        end
                    end
                end
                ST_WR: begin
                    // The strobe has already been issued, so a lost halt only flags the response.
                    extra_we_q  <= 1'b0;
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_addr_q  <= extra_addr_q;
                    rsp_data_q  <= data_q;
                    rsp_last_q  <= 1'b1;
                    rsp_err_q   <= !halted_i;
                end
                ST_RD_ADDR: begin
                    if (!halted_i) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_addr_q  <= extra_addr_q;
                        rsp_data_q  <= '0;
                        rsp_last_q  <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        state_q <= ST_RD_CAP;
                    end
                end
                ST_RD_CAP: begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_addr_q  <= extra_addr_q;
                    if (!halted_i) begin
                        rsp_data_q <= '0;
                        rsp_last_q <= 1'b1;
                        rsp_err_q  <= 1'b1;
                    end else begin
                        rsp_data_q <= extra_read_data_i;
                        rsp_last_q <= (op_q != OP_DUMP) || (idx_q == IDX_LAST);
                        rsp_err_q  <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (rsp_hs_s) begin
                        rsp_valid_q <= 1'b0;
                        if ((op_q == OP_DUMP) && (idx_q != IDX_LAST) && !rsp_err_q) begin
                            idx_q        <= idx_next_s;
                            extra_addr_q <= idx_next_s;
                            state_q      <= ST_RD_ADDR;
                        end else begin
                            state_q       <= ST_IDLE;
                            halt_req_q    <= 1'b0;
                            extra_addr_q  <= '0;
                            extra_wdata_q <= '0;
                            rsp_addr_q    <= '0;
                            rsp_data_q    <= '0;
                            rsp_last_q    <= 1'b0;
                            rsp_err_q     <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    halt_req_q    <= 1'b0;
                    extra_we_q    <= 1'b0;
                    extra_addr_q  <= '0;
                    extra_wdata_q <= '0;
                    rsp_valid_q   <= 1'b0;
                end
            endcase
        end
    end

    assign halt_req_o           = halt_req_q;
    assign extra_addr_o         = extra_addr_q;
    assign extra_write_enable_o = extra_we_q;
    assign extra_write_data_o   = extra_wdata_q;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_addr         = rsp_addr_q;
    assign bus.rsp_data         = rsp_data_q;
    assign bus.rsp_last         = rsp_last_q;
    assign bus.rsp_err          = rsp_err_q;

endmodule

// File: tb/tb_reg_debug_access.sv
// Bench for reg_debug_access: a register file and halt responder surround the block,
// and a scoreboard of expected responses is matched against each response handshake.
module tb_reg_debug_access;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        halt_req;
    logic        halted;
    logic [4:0]  extra_addr;
    logic        extra_we;
    logic [31:0] extra_wdata;
    logic [31:0] extra_rdata;

    always #5 CLK = ~CLK;

    reg_debug_access_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    reg_debug_access #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK                  (CLK),
        .RSTn                 (RSTn),
        .bus                  (bus),
        .halt_req_o           (halt_req),
        .halted_i             (halted),
        .extra_addr_o         (extra_addr),
        .extra_write_enable_o (extra_we),
        .extra_write_data_o   (extra_wdata),
        .extra_read_data_i    (extra_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int halt_delay = 0;
    bit drop_halt = 1'b0;
    bit rand_ready = 1'b0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
        logic        err;
        bit          chk_data;
        int          exp_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_regs [32];
    logic [31:0] regs [32];
    logic        rf_init_done = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d, input logic l,
                        input logic e, input bit cd, input int ec);
        exp_t x;
        x.addr = a; x.data = d; x.last = l; x.err = e; x.chk_data = cd; x.exp_cyc = ec;
        sb.push_back(x);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Register file model: x0 reads as zero, read data registered one cycle after the address.
    always @(posedge CLK) begin
        if (!rf_init_done) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'(i * 17);
            rf_init_done <= 1'b1;
        end else if (extra_we && extra_addr != 5'd0) begin
            regs[extra_addr] <= extra_wdata;
        end
        extra_rdata <= (extra_addr == 5'd0) ? 32'd0 : regs[extra_addr];
    end

    // Core halt responder: acknowledges halt_req after halt_delay cycles, or drops on demand.
    initial begin
        int hcnt;
        hcnt = 0;
        halted = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (!halt_req) begin
                hcnt = 0;
                halted = 1'b0;
            end else if (drop_halt) begin
                halted = 1'b0;
            end else if (hcnt >= halt_delay) begin
                halted = 1'b1;
            end else begin
                hcnt++;
                halted = 1'b0;
            end
        end
    end

    // Response-side backpressure, optionally random.
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            bus.rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Response monitor: latency of each beat, stability while stalled, payload on handshake.
    initial begin
        bit          in_beat;
        logic [4:0]  h_addr;
        logic [31:0] h_data;
        logic        h_last;
        logic        h_err;
        exp_t        e;
        in_beat = 1'b0;
        forever begin
            @(negedge CLK);
            if (RSTn && bus.rsp_valid) begin
                if (in_beat) begin
                    check("stall_addr", bus.rsp_addr, h_addr);
                    check("stall_data", bus.rsp_data, h_data);
                    check("stall_last", bus.rsp_last, h_last);
                    check("stall_err",  bus.rsp_err,  h_err);
                end else begin
                    in_beat = 1'b1;
                    if (sb.size() == 0)
                        check("spurious_rsp", bus.rsp_valid, 1'b0);
                    else if (sb[0].exp_cyc >= 0)
                        check("rsp_latency", cyc, sb[0].exp_cyc);
                end
                h_addr = bus.rsp_addr; h_data = bus.rsp_data;
                h_last = bus.rsp_last; h_err  = bus.rsp_err;
                if (bus.rsp_ready) begin
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("rsp_addr", bus.rsp_addr, e.addr);
                        if (e.chk_data) check("rsp_data", bus.rsp_data, e.data);
                        check("rsp_last", bus.rsp_last, e.last);
                        check("rsp_err",  bus.rsp_err,  e.err);
                    end
                    in_beat = 1'b0;
                end
            end else begin
                in_beat = 1'b0;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d,
                        output int acc);
        int k;
        k = 0;
        @(posedge CLK);
        #1;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = a; bus.req_data = d;
        @(negedge CLK);
        while (!bus.req_ready && k < 300) begin
            @(negedge CLK);
            k++;
        end
        check("req_accept", bus.req_ready, 1'b1);
        @(posedge CLK);
        #1;
        acc = cyc;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    task automatic wait_beat(input logic [4:0] a, input string tag);
        int k;
        k = 0;
        @(negedge CLK);
        while (!(bus.rsp_valid && bus.rsp_addr == a) && k < 400) begin
            @(negedge CLK);
            k++;
        end
        check(tag, bus.rsp_addr, a);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = 5'd0; bus.req_data = 32'd0;
        for (int i = 0; i < 32; i++) exp_regs[i] = 32'(i) * 32'h11;

        repeat (3) @(negedge CLK);
        check("rst_req_ready",   bus.req_ready, 1'b1);
        check("rst_rsp_valid",   bus.rsp_valid, 1'b0);
        check("rst_halt_req",    halt_req,      1'b0);
        check("rst_extra_we",    extra_we,      1'b0);
        check("rst_extra_addr",  extra_addr,    5'd0);
        check("rst_extra_wdata", extra_wdata,   32'd0);
        check("rst_rsp_data",    bus.rsp_data,  32'd0);
        check("rst_rsp_last",    bus.rsp_last,  1'b0);
        RSTn = 1'b1;

        // Full dump with random response stalls.
        rand_ready = 1'b1;
        send(2'b10, 5'd9, 32'd0, acc);
        for (int k = 0; k < 32; k++)
            push(5'(k), exp_regs[k], (k == 31), 1'b0, 1'b1, (k == 0) ? acc + 3 : -1);
        drain(3000);
        rand_ready = 1'b0;

        // Write x5, checking the strobe lands in cycle 2 only.
        send(2'b01, 5'd5, 32'hDEADBEEF, acc);
        push(5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, acc + 2);
        exp_regs[5] = 32'hDEADBEEF;
        @(negedge CLK);
        check("wr_c1_halt_req", halt_req, 1'b1);
        check("wr_c1_we",       extra_we, 1'b0);
        @(negedge CLK);
        check("wr_c2_we",    extra_we,    1'b1);
        check("wr_c2_addr",  extra_addr,  5'd5);
        check("wr_c2_wdata", extra_wdata, 32'hDEADBEEF);
        @(negedge CLK);
        check("wr_c3_we", extra_we, 1'b0);
        drain(50);

        send(2'b00, 5'd5, 32'd0, acc);
        push(5'd5, exp_regs[5], 1'b1, 1'b0, 1'b1, acc + 3);
        drain(50);

        // x0 write is issued but discarded by the register file.
        send(2'b01, 5'd0, 32'h12345678, acc);
        push(5'd0, 32'h12345678, 1'b1, 1'b0, 1'b1, acc + 2);
        drain(50);
        send(2'b00, 5'd0, 32'd0, acc);
        push(5'd0, exp_regs[0], 1'b1, 1'b0, 1'b1, acc + 3);
        drain(50);

        // Illegal opcode: error response in cycle 1, no halt.
        send(2'b11, 5'd3, 32'hAAAA5555, acc);
        push(5'd3, 32'd0, 1'b1, 1'b1, 1'b1, acc);
        @(negedge CLK);
        check("ill_halt_req_c1", halt_req, 1'b0);
        @(negedge CLK);
        check("ill_halt_req_c2", halt_req, 1'b0);
        check("ill_req_ready",   bus.req_ready, 1'b1);
        drain(20);

        // Delayed halt acknowledge: register file untouched until halted.
        halt_delay = 10;
        send(2'b00, 5'd5, 32'd0, acc);
        push(5'd5, exp_regs[5], 1'b1, 1'b0, 1'b1, acc + 13);
        for (int i = 0; i <= 10; i++) begin
            @(negedge CLK);
            check("hd_idle_we",   extra_we,   1'b0);
            check("hd_idle_addr", extra_addr, 5'd0);
        end
        @(negedge CLK);
        check("hd_rd_addr", extra_addr, 5'd5);
        wait_beat(5'd5, "hd_rsp_seen");
        check("hd_halt_req_at_hs", halt_req, 1'b1);
        @(negedge CLK);
        check("hd_halt_req_after", halt_req, 1'b0);
        check("hd_req_ready",      bus.req_ready, 1'b1);
        drain(20);
        halt_delay = 0;

        // Halt lost during dump beat 7.
        send(2'b10, 5'd0, 32'd0, acc);
        for (int k = 0; k < 7; k++)
            push(5'(k), exp_regs[k], 1'b0, 1'b0, 1'b1, acc + 3 + 3 * k);
        push(5'd7, 32'd0, 1'b1, 1'b1, 1'b0, acc + 23);
        wait_beat(5'd6, "hl_beat6_seen");
        drop_halt = 1'b1;
        drain(100);
        @(negedge CLK);
        drop_halt = 1'b0;
        check("hl_idle_ready",    bus.req_ready, 1'b1);
        check("hl_idle_halt_req", halt_req,      1'b0);

        // Reset asserted during dump beat 3.
        send(2'b10, 5'd0, 32'd0, acc);
        for (int k = 0; k < 32; k++)
            push(5'(k), exp_regs[k], (k == 31), 1'b0, 1'b1, -1);
        wait_beat(5'd3, "rst_beat3_seen");
        #1;
        RSTn = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_halt_req",  halt_req,      1'b0);
        check("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("mid_rst_req_ready", bus.req_ready, 1'b1);
        check("mid_rst_we",        extra_we,      1'b0);
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;

        send(2'b00, 5'd9, 32'd0, acc);
        push(5'd9, exp_regs[9], 1'b1, 1'b0, 1'b1, acc + 3);
        drain(50);

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
